alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, sets the datapath width in bits; legal range 4..64.
REQ-002 Localparam SHW = clog2(WIDTH) sets the shift-amount width taken from data_b[SHW-1:0].
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The ports SHALL be, in this order:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block accepts an operation this cycle.
- codop  in  4  operation select.
- data_a  in  WIDTH  operand A.
- data_b  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  result.
- neg, zero, carry, overflow  out  1 each  result flags.
- busy  out  1  multiply in progress.

Function
REQ-005 An operation is accepted on a rising edge where in_valid=1 and in_ready=1; codop, data_a and data_b are captured only at acceptance.
REQ-006 in_ready SHALL be 1 iff state=IDLE and (out_valid=0 or out_ready=1), a combinational function of state and out_ready.
REQ-007 The opcodes SHALL be:
- 0: b+a
- 1: b-a
- 2: (a>b unsigned) ? 1 : 0
- 3: a&b
- 4: a|b
- 5: a^b
- 6: a<<b[SHW-1:0]
- 7: logical a>>b[SHW-1:0]
- 8: arithmetic a>>>b[SHW-1:0]
- 9: a+b
- 10: a-b
- 11: a*b, low WIDTH bits
- 12-15: result 0 with all flags 0 except zero=1
REQ-008 All arithmetic is modulo 2^WIDTH.
REQ-009 The carry flag SHALL be set as follows:
- add (0, 9): carry-out of bit WIDTH-1.
- sub (1, 10): borrow, i.e. minuend<subtrahend unsigned.
- all other ops: 0.
REQ-010 The overflow flag SHALL be set as follows:
- add/sub: two's-complement signed overflow.
- mul (11): 1 iff the full 2*WIDTH product's upper half is nonzero.
- all other ops: 0.
REQ-011 neg SHALL equal out[WIDTH-1]; zero SHALL equal (out==0).
- Both are registered together with out.
- Both are meaningful only while out_valid=1.
REQ-012 The state machine SHALL have states IDLE and MUL.
- IDLE -> MUL on acceptance of codop 11.
- MUL -> IDLE after WIDTH iteration cycles.
REQ-013 Opcodes other than 11 SHALL complete in 1 cycle: out, flags and out_valid=1 are registered on the accept edge.
REQ-014 Multiply SHALL be shift-add, one operand bit per cycle.
- busy=1 from the accept edge until result load.
- out_valid=1 is set exactly WIDTH edges after the accept edge.
REQ-015 While out_valid=1 and out_ready=0, out, flags and out_valid SHALL hold stable.
REQ-016 out_valid clears on an edge with out_ready=1 unless a new single-cycle operation is accepted on the same edge.
- If one is, the new result replaces the old and out_valid stays 1, giving back-to-back throughput of 1 op/cycle.
REQ-017 A multiply SHALL NOT start while an unconsumed result is pending (REQ-006).
- out_valid=0 for the whole MUL period unless the prior result is still held.
- A prior result is not possible because of REQ-006.
REQ-018 in_valid=1 with in_ready=0 SHALL have no effect; no operation is lost or duplicated.
REQ-019 Shift amounts are data_b[SHW-1:0] only; upper data_b bits are ignored.
REQ-020 The arithmetic right shift (op 8) SHALL replicate data_a[WIDTH-1].

Reset
REQ-021 While rst=1, independent of clk, the following SHALL hold:
- state=IDLE, out=0, all flags=0, out_valid=0, busy=0.
- in_ready=0 while rst=1; in_ready=1 after release.
REQ-022 Reset during MUL SHALL abort the multiply with no result produced.
REQ-023 After rst deasserts, the first acceptance may occur on the first rising edge.

Verification (WIDTH=16)
REQ-024 Add carry: codop 0, a=0xFFFF, b=0x0001 -> next edge out=0x0000, zero=1, carry=1, overflow=0, neg=0, out_valid=1.
REQ-025 Signed sub: codop 10, a=0x8000, b=0x0001 -> out=0x7FFF, overflow=1, carry=0, neg=0.
REQ-026 Multiply: codop 11, a=0x0100, b=0x0100 -> busy=1 and in_ready=0 for 16 cycles; out_valid rises exactly 16 edges after accept; out=0x0000, zero=1, overflow=1. Also a=7, b=6 -> out=42 (0x002A), overflow=0.
REQ-027 Backpressure: issue codop 3 (a=0xF0F0, b=0x0FF0) with out_ready=0 -> out=0x00F0 held and in_ready=0 for 5 cycles; raising out_ready with in_valid=1, codop 8, a=0x8000, b=0x0004 -> next result 0xF800, neg=1.
REQ-028 Reset mid-op: assert rst on cycle 5 of a multiply -> out_valid=0, busy=0, out=0 immediately; after release, codop 9 with 3+4 -> out=7 after 1 cycle.
REQ-029 Streaming: 8 consecutive single-cycle ops with out_ready=1 held -> 8 results on 8 consecutive edges, in order, none dropped.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: single-cycle ALU with a shift-add multiplier and valid/ready handshakes on both sides.
module alu_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       codop,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             neg,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);
   typedef enum logic {IDLE, MUL} state_t;
   state_t state, state_nx;
   logic [2*WIDTH-1:0] acc, mcand, acc_nx;
   logic [WIDTH-1:0] mplier, x, y, res;
   logic [WIDTH:0] sum;
   logic [SHW-1:0] cnt, sh;
   logic sub, arith, c_o, v_o, accept, last;
   assign in_ready = !rst && state == IDLE && (!out_valid || out_ready);
   assign accept = in_valid && in_ready;
   assign busy = state == MUL;
   assign last = cnt == SHW'(WIDTH - 1);
   assign acc_nx = acc + (mplier[0] ? mcand : '0);
   // x/y are ordered as minuend/subtrahend so one adder serves every add and sub opcode
   always_comb begin
      sh = data_b[SHW-1:0];
      sub = codop == 4'd1 || codop == 4'd10;
      arith = codop == 4'd0 || codop == 4'd9 || sub;
      x = codop == 4'd1 ? data_b : data_a;
      y = codop == 4'd1 ? data_a : data_b;
      sum = sub ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
      c_o = arith && sum[WIDTH];
      v_o = arith && ((x[WIDTH-1] ^ y[WIDTH-1]) == sub) && (sum[WIDTH-1] ^ x[WIDTH-1]);
      res = '0;
      case (codop)
         4'd0, 4'd1, 4'd9, 4'd10: res = sum[WIDTH-1:0];
         4'd2: res = WIDTH'(data_a > data_b);
         4'd3: res = data_a & data_b;
         4'd4: res = data_a | data_b;
         4'd5: res = data_a ^ data_b;
         4'd6: res = data_a << sh;
         4'd7: res = data_a >> sh;
         4'd8: res = $signed(data_a) >>> sh;
         default: res = '0;
      endcase
   end
   always_comb begin
      state_nx = state;
      if (state == IDLE && accept && codop == 4'd11) state_nx = MUL;
      if (state == MUL && last) state_nx = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= '0;
         {neg, zero, carry, overflow} <= '0;
         out_valid <= 1'b0;
         acc <= '0;
         mcand <= '0;
         mplier <= '0;
         cnt <= '0;
      end else if (state == MUL) begin
         acc <= acc_nx;
         mcand <= mcand << 1;
         mplier <= mplier >> 1;
         cnt <= cnt + 1'b1;
         if (last) begin
            out <= acc_nx[WIDTH-1:0];
            neg <= acc_nx[WIDTH-1];
            zero <= acc_nx[WIDTH-1:0] == '0;
            carry <= 1'b0;
            overflow <= |acc_nx[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
         end
      end else if (accept && codop == 4'd11) begin
         acc <= '0;
         mcand <= {{WIDTH{1'b0}}, data_a};
         mplier <= data_b;
         cnt <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         out <= res;
         neg <= res[WIDTH-1];
         zero <= res == '0;
         carry <= c_o;
         overflow <= v_o;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH=16.
module tb_alu_pipe;
   logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
   logic in_ready, out_valid, neg, zero, carry, overflow, busy;
   logic [3:0] codop = 0;
   logic [15:0] data_a = 0, data_b = 0, out;
   typedef struct packed {logic [15:0] o; logic n, z, c, v;} res_t;
   res_t exp_q[$], got_q[$];
   int n_chk = 0, n_fail = 0;

   alu_pipe #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .codop(codop),
      .data_a(data_a), .data_b(data_b), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .neg(neg), .zero(zero), .carry(carry), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int ua = int'(a), ub = int'(b), sa = int'($signed(a)), sb = int'($signed(b));
      int sh = ub & 15, r = 0, s = 0;
      longint p;
      logic c = 0, v = 0;
      res_t m;
      case (op)
         0, 9: begin r = ua + ub; c = r > 65535; s = sa + sb; v = s > 32767 || s < -32768; end
         1: begin r = ub - ua; c = ub < ua; s = sb - sa; v = s > 32767 || s < -32768; end
         10: begin r = ua - ub; c = ua < ub; s = sa - sb; v = s > 32767 || s < -32768; end
         2: r = int'(ua > ub);
         3: r = ua & ub;
         4: r = ua | ub;
         5: r = ua ^ ub;
         6: r = ua << sh;
         7: r = ua >> sh;
         8: r = sa >>> sh;
         11: begin p = longint'(ua) * longint'(ub); r = int'(p); v = (p >> 16) != 0; end
         default: r = 0;
      endcase
      m.o = r[15:0];
      m.n = m.o[15];
      m.z = m.o == 0;
      m.c = c;
      m.v = v;
      return m;
   endfunction

   // Records what is accepted and what is consumed on the coming edge, then steps past it.
   task automatic cycle(output bit acc);
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got_q.push_back({out, neg, zero, carry, overflow});
      if (acc) exp_q.push_back(model(codop, data_a, data_b));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit a;
      repeat (n) cycle(a);
   endtask

   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      bit acc = 0;
      codop = op; data_a = a; data_b = b; in_valid = 1;
      for (int k = 0; k < 40 && !acc; k++) begin
         cycle(acc);
         if (!acc) out_ready = 1;
      end
      in_valid = 0;
      n_chk++;
      if (!acc) begin n_fail++; $display("FAIL issue_timeout: op %0d accepted=%0d required=1", op, acc); end
   endtask

   task automatic test_reset();
      #1 rst = 1;
      #2;
      n_chk++;
      if ({out_valid, busy, in_ready, out, neg, zero, carry, overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: vld=%b busy=%b rdy=%b out=%h flags=%b required all 0",
                  out_valid, busy, in_ready, out, {neg, zero, carry, overflow});
      end
      @(posedge clk); #1 rst = 0; #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_add_sub();
      out_ready = 1;
      issue(0, 16'hFFFF, 16'h0001);
      n_chk++;
      if ({out_valid, out, neg, zero, carry, overflow} !== {1'b1, 16'h0000, 4'b0110}) begin
         n_fail++; $display("FAIL add_carry: vld=%b out=%h nzcv=%b required 1 0000 0110",
                            out_valid, out, {neg, zero, carry, overflow});
      end
      issue(10, 16'h8000, 16'h0001);
      n_chk++;
      if ({out, neg, zero, carry, overflow} !== {16'h7FFF, 4'b0001}) begin
         n_fail++; $display("FAIL signed_sub: out=%h nzcv=%b required 7fff 0001", out, {neg, zero, carry, overflow});
      end
      issue(1, 16'h0005, 16'h0003);
      issue(2, 16'h0009, 16'h0003);
      issue(6, 16'h0003, 16'hFFF4);
      issue(13, 16'h1234, 16'h5678);
      idle(2);
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         res_t g = got_q.pop_front(), e = exp_q.pop_front();
         n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL sb_add_sub: got %h required %h", g, e); end
      end
   endtask

   task automatic test_mul();
      issue(11, 16'h0100, 16'h0100);
      for (int i = 0; i < 16; i++) begin
         n_chk++;
         if ({busy, out_valid, in_ready} !== 3'b100) begin
            n_fail++; $display("FAIL mul_busy[%0d]: busy/vld/rdy=%b required 100", i, {busy, out_valid, in_ready});
         end
         idle(1);
      end
      n_chk++;
      if ({out_valid, busy, out, zero, overflow} !== {2'b10, 16'h0000, 2'b11}) begin
         n_fail++; $display("FAIL mul_overflow: vld=%b busy=%b out=%h z=%b v=%b required 1 0 0000 1 1",
                            out_valid, busy, out, zero, overflow);
      end
      issue(11, 16'd7, 16'd6);
      idle(16);
      n_chk++;
      if ({out_valid, out, overflow} !== {1'b1, 16'h002A, 1'b0}) begin
         n_fail++; $display("FAIL mul_7x6: vld=%b out=%h v=%b required 1 002a 0", out_valid, out, overflow);
      end
      idle(2);
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         res_t g = got_q.pop_front(), e = exp_q.pop_front();
         n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL sb_mul: got %h required %h", g, e); end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 0;
      issue(3, 16'hF0F0, 16'h0FF0);
      repeat (5) begin
         n_chk++;
         if ({out_valid, in_ready, out} !== {2'b10, 16'h00F0}) begin
            n_fail++; $display("FAIL bp_hold: vld=%b rdy=%b out=%h required 1 0 00f0", out_valid, in_ready, out);
         end
         idle(1);
      end
      out_ready = 1;
      issue(8, 16'h8000, 16'h0004);
      n_chk++;
      if ({out_valid, out, neg} !== {1'b1, 16'hF800, 1'b1}) begin
         n_fail++; $display("FAIL bp_asr: vld=%b out=%h n=%b required 1 f800 1", out_valid, out, neg);
      end
      idle(2);
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         res_t g = got_q.pop_front(), e = exp_q.pop_front();
         n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL sb_bp: got %h required %h", g, e); end
      end
   endtask

   task automatic test_reset_mid_mul();
      issue(11, 16'h1234, 16'h5678);
      idle(4);
      rst = 1;
      #2;
      n_chk++;
      if ({out_valid, busy, in_ready, out} !== '0) begin
         n_fail++; $display("FAIL reset_mid_mul: vld=%b busy=%b rdy=%b out=%h required all 0",
                            out_valid, busy, in_ready, out);
      end
      void'(exp_q.pop_back());
      @(posedge clk); #1 rst = 0;
      issue(9, 16'd3, 16'd4);
      n_chk++;
      if ({out_valid, out} !== {1'b1, 16'd7}) begin
         n_fail++; $display("FAIL post_reset_add: vld=%b out=%h required 1 0007", out_valid, out);
      end
      idle(2);
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         res_t g = got_q.pop_front(), e = exp_q.pop_front();
         n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL sb_reset: got %h required %h", g, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12};
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         issue(ops[i], 16'($urandom), 16'($urandom));
         n_chk++;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b required 1", i, out_valid); end
      end
      idle(2);
      n_chk++;
      if (got_q.size() != 8) begin n_fail++; $display("FAIL stream_count: got %0d required 8", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         res_t g = got_q.pop_front(), e = exp_q.pop_front();
         n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL sb_stream: got %h required %h", g, e); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      end
      out_ready = 1;
      idle(20);
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         res_t g = got_q.pop_front(), e = exp_q.pop_front();
         n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL sb_random: got %h required %h", g, e); end
      end
      n_chk++;
      if (got_q.size() != 0 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL queues_empty: got %0d/%0d left required 0/0", got_q.size(), exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
